frame_write_sequencer: RTL and testbench
========================================

FRAME_WRITE_SEQUENCER -- requirements
Module: frame_write_sequencer

Interface
REQ-001 The block SHALL have parameter PIXELS, default 10, meaning pixels per line (1..15).
REQ-002 The block SHALL have parameter LINES, default 10, meaning lines per frame (1..10).
REQ-003 Port Clock  input  1  single rising-edge clock for all state.
REQ-004 Port Reset  input  1  reset, synchronous and active-high.
REQ-005 Port Start  input  1  single-cycle request to begin one frame; sampled only in IDLE.
REQ-006 Port DataIn  input  8  colour byte from source, order R,G,B per pixel.
REQ-007 Port DataValid  input  1  DataIn valid this cycle.
REQ-008 Port DataReady  output  1  sequencer accepts DataIn this cycle.
REQ-009 Port FrameOut  output  8  registered byte to frame buffer FrameIn.
REQ-010 Port LineOut  output  4  registered line address of FrameOut.
REQ-011 Port PxOut  output  4  registered pixel address of FrameOut.
REQ-012 Port ColorPhase  output  2  registered colour of FrameOut: 01 Red, 10 Green, 11 Blue, 00 none.
REQ-013 Port WriteStrobe  output  1  one-cycle write enable for FrameOut/LineOut/PxOut/ColorPhase.
REQ-014 Port FrameBufferEnable  output  1  bank select to frame buffer (0 lower bank, 1 bank offset +2 lines).
REQ-015 Port Busy  output  1  high in any state except IDLE.
REQ-016 Port FrameDone  output  1  one-cycle pulse at frame completion.

Function
REQ-017 FSM states SHALL be IDLE, RED, GREEN, BLUE, DONE.
REQ-018 IDLE: Start=1 -> RED, internal pixel/line counters cleared to 0; otherwise stay.
REQ-019 DataReady SHALL be 1 exactly in RED, GREEN, BLUE (combinational on state); transfer = DataValid & DataReady.
REQ-020 On transfer in RED/GREEN/BLUE: next state GREEN/BLUE/RED respectively; no transfer -> state and counters held.
REQ-021 Transfer in cycle N SHALL produce WriteStrobe=1 in cycle N+1 with FrameOut=DataIn(N), LineOut/PxOut = counters at N, ColorPhase = state at N; WriteStrobe=0 in every other cycle.
REQ-022 FrameOut/LineOut/PxOut/ColorPhase SHALL hold last values when WriteStrobe=0.
REQ-023 Transfer in BLUE: pixel counter +1; at PIXELS-1 wraps to 0 and line counter +1.
REQ-024 Transfer in BLUE at pixel PIXELS-1 and line LINES-1: next state DONE instead of RED.
REQ-025 DONE: FrameDone=1 for that one cycle (coincides with final WriteStrobe), then -> IDLE unconditionally.
REQ-026 Start outside IDLE SHALL be ignored; Start in DONE is not queued.
REQ-027 DataIn/DataValid in IDLE or DONE SHALL be ignored (no strobe).
REQ-028 One frame SHALL be exactly 3*PIXELS*LINES transfers (300 at defaults).

Reset
REQ-029 Reset=1 at a Clock edge SHALL force IDLE, counters 0, FrameOut 0, LineOut 0, PxOut 0, ColorPhase 00, WriteStrobe 0, FrameDone 0, FrameBufferEnable 0; Busy and DataReady thus 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no FrameDone and no further strobes; Reset overrides Start and transfers in the same cycle.

Configuration
REQ-031 Macro FRAME_SEQ_BANK_SWAP_EN defined: FrameBufferEnable SHALL toggle on the DONE->IDLE transition, so successive frames alternate banks; it SHALL be constant across a frame.
REQ-032 Macro FRAME_SEQ_BANK_SWAP_EN undefined: FrameBufferEnable SHALL be tied 0.

Verification
REQ-033 Reset, Start, 300 back-to-back valid bytes 0x00..0x2B wrapping -> 300 strobes, first at Line0/Px0/Red=0x00, 4th at Px1/Red, last Line9/Px9/Blue; FrameDone one pulse with last strobe; Busy low next cycle.
REQ-034 DataValid toggled 1/0 each cycle -> strobe only after valid cycles, address sequence identical to REQ-033, frame takes 599 cycles from first transfer.
REQ-035 Start pulsed at transfer 50 of a frame -> ignored, single FrameDone after 300 transfers.
REQ-036 Reset asserted after transfer 100 -> next cycle all outputs at reset values, no FrameDone; new Start restarts at Line0/Px0/Red.
REQ-037 Two consecutive frames with FRAME_SEQ_BANK_SWAP_EN -> FrameBufferEnable 0 in frame 1, 1 in frame 2; without macro -> 0 in both.
REQ-038 PIXELS=2, LINES=1 -> 6 transfers, PxOut 0,0,0,1,1,1, FrameDone with 6th strobe.

Source files
------------

// File: rtl/frame_write_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// frame_write_sequencer
//
// Accepts a stream of colour bytes (R, G, B per pixel) and writes each byte to
// a frame buffer with its line address, pixel address and colour phase.
// One frame is PIXELS x LINES pixels, i.e. 3*PIXELS*LINES byte transfers.
//
// State table:
//   state   | meaning
//   IDLE    | waiting for Start; counters cleared when Start is seen
//   RED     | ready for the red byte of the current pixel
//   GREEN   | ready for the green byte of the current pixel
//   BLUE    | ready for the blue byte; advances pixel/line counters
//   DONE    | one cycle, FrameDone pulses together with the final strobe
//
// Ports:
//   Clock             rising-edge clock for all state
//   Reset             synchronous, active-high reset
//   Start             one-cycle frame request, only looked at in IDLE
//   DataIn[7:0]       colour byte from the source
//   DataValid         DataIn valid this cycle
//   DataReady         sequencer accepts DataIn this cycle (RED/GREEN/BLUE)
//   FrameOut[7:0]     registered byte to the frame buffer
//   LineOut[3:0]      registered line address of FrameOut
//   PxOut[3:0]        registered pixel address of FrameOut
//   ColorPhase[1:0]   registered colour of FrameOut: 01 R, 10 G, 11 B
//   WriteStrobe       one-cycle write enable, the cycle after each transfer
//   FrameBufferEnable bank select for the frame buffer
//   Busy              high in every state but IDLE
//   FrameDone         one-cycle pulse at frame completion
//
// Build option:
//   FRAME_SEQ_BANK_SWAP_EN  when defined, FrameBufferEnable toggles on each
//                           DONE->IDLE transition so successive frames land in
//                           alternating banks; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module frame_write_sequencer #(
    parameter int PIXELS = 10,
    parameter int LINES  = 10
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] DataIn,
    input  logic       DataValid,
    output logic       DataReady,
    output logic [7:0] FrameOut,
    output logic [3:0] LineOut,
    output logic [3:0] PxOut,
    output logic [1:0] ColorPhase,
    output logic       WriteStrobe,
    output logic       FrameBufferEnable,
    output logic       Busy,
    output logic       FrameDone
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RED   = 3'd1,
        S_GREEN = 3'd2,
        S_BLUE  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_PX   = 4'(PIXELS - 1);
    localparam logic [3:0] LAST_LINE = 4'(LINES - 1);

    state_t     state_q, state_d;
    logic [3:0] px_q, px_d;
    logic [3:0] line_q, line_d;
    logic [7:0] frame_out_q, frame_out_d;
    logic [3:0] line_out_q, line_out_d;
    logic [3:0] px_out_q, px_out_d;
    logic [1:0] color_q, color_d;
    logic       strobe_q, strobe_d;
    logic       done_q, done_d;
    logic       bank_q, bank_d;

    logic       ready;
    logic       xfer;
    logic [1:0] cur_color;

    always_comb begin
        ready     = 1'b0;
        cur_color = 2'b00;
        case (state_q)
            S_RED:   begin ready = 1'b1; cur_color = 2'b01; end
            S_GREEN: begin ready = 1'b1; cur_color = 2'b10; end
            S_BLUE:  begin ready = 1'b1; cur_color = 2'b11; end
            default: begin ready = 1'b0; cur_color = 2'b00; end
        endcase
    end

    assign xfer = DataValid & ready;

    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        line_d      = line_q;
        frame_out_d = frame_out_q;
        line_out_d  = line_out_q;
        px_out_d    = px_out_q;
        color_d     = color_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RED;
                    px_d    = 4'd0;
                    line_d  = 4'd0;
                end
            end
            S_RED: begin
                if (xfer) state_d = S_GREEN;
            end
            S_GREEN: begin
                if (xfer) state_d = S_BLUE;
            end
            S_BLUE: begin
                if (xfer) begin
                    if (px_q == LAST_PX) begin
                        px_d = 4'd0;
                        if (line_q == LAST_LINE) begin
                            // Final byte of the frame: FrameDone lines up
                            // with the strobe carrying this byte.
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            line_d  = line_q + 4'd1;
                            state_d = S_RED;
                        end
                    end else begin
                        px_d    = px_q + 4'd1;
                        state_d = S_RED;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Address/colour captured from the transfer cycle, presented one
        // cycle later alongside the strobe; held otherwise.
        if (xfer) begin
            frame_out_d = DataIn;
            line_out_d  = line_q;
            px_out_d    = px_q;
            color_d     = cur_color;
            strobe_d    = 1'b1;
        end

`ifdef FRAME_SEQ_BANK_SWAP_EN
        bank_d = (state_q == S_DONE) ? ~bank_q : bank_q;
`else
        bank_d = 1'b0;
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            px_q        <= 4'd0;
            line_q      <= 4'd0;
            frame_out_q <= 8'd0;
            line_out_q  <= 4'd0;
            px_out_q    <= 4'd0;
            color_q     <= 2'b00;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            bank_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            px_q        <= px_d;
            line_q      <= line_d;
            frame_out_q <= frame_out_d;
            line_out_q  <= line_out_d;
            px_out_q    <= px_out_d;
            color_q     <= color_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            bank_q      <= bank_d;
        end
    end

    assign DataReady         = ready;
    assign Busy              = (state_q != S_IDLE);
    assign FrameOut          = frame_out_q;
    assign LineOut           = line_out_q;
    assign PxOut             = px_out_q;
    assign ColorPhase        = color_q;
    assign WriteStrobe       = strobe_q;
    assign FrameDone         = done_q;
    assign FrameBufferEnable = bank_q;

endmodule

// File: tb/tb_frame_write_sequencer.sv
`timescale 1ns/1ps
// Testbench for frame_write_sequencer: a default-size instance (10x10) and a
// small instance (PIXELS=2, LINES=1). Expected writes are queued by the
// stimulus; monitors pop and compare on every WriteStrobe.
module tb_frame_write_sequencer;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] line;
        logic [3:0] px;
        logic [1:0] color;
        logic       done;
        logic       bank;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start, DataValid;
    logic [7:0] DataIn;
    logic       DataReady, WriteStrobe, FrameBufferEnable, Busy, FrameDone;
    logic [7:0] FrameOut;
    logic [3:0] LineOut, PxOut;
    logic [1:0] ColorPhase;

    logic       Start2, DataValid2;
    logic [7:0] DataIn2;
    logic       DataReady2, WriteStrobe2, FrameBufferEnable2, Busy2, FrameDone2;
    logic [7:0] FrameOut2;
    logic [3:0] LineOut2, PxOut2;
    logic [1:0] ColorPhase2;

    int   checks = 0;
    int   errors = 0;
    int   strobes1 = 0;
    int   strobes2 = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t last1 = '0;
    logic rst_prev = 1'b1;
    logic exp_bank = 1'b0;

    always #5 Clock = ~Clock;

    frame_write_sequencer #(.PIXELS(10), .LINES(10)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .DataIn(DataIn),
        .DataValid(DataValid), .DataReady(DataReady), .FrameOut(FrameOut),
        .LineOut(LineOut), .PxOut(PxOut), .ColorPhase(ColorPhase),
        .WriteStrobe(WriteStrobe), .FrameBufferEnable(FrameBufferEnable),
        .Busy(Busy), .FrameDone(FrameDone)
    );

    frame_write_sequencer #(.PIXELS(2), .LINES(1)) dut2 (
        .Clock(Clock), .Reset(Reset), .Start(Start2), .DataIn(DataIn2),
        .DataValid(DataValid2), .DataReady(DataReady2), .FrameOut(FrameOut2),
        .LineOut(LineOut2), .PxOut(PxOut2), .ColorPhase(ColorPhase2),
        .WriteStrobe(WriteStrobe2), .FrameBufferEnable(FrameBufferEnable2),
        .Busy(Busy2), .FrameDone(FrameDone2)
    );

    always @(posedge Clock) rst_prev <= Reset;

    // Monitor for the 10x10 instance: every strobe must match the queue head;
    // every other cycle the outputs must hold the last written values.
    always @(negedge Clock) begin
        exp_t e;
        if (rst_prev) last1 = '0;
        checks++;
        if (WriteStrobe) begin
            strobes1++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL stray_strobe got data=%h line=%0d px=%0d col=%b required no strobe",
                         FrameOut, LineOut, PxOut, ColorPhase);
            end else begin
                e = q1.pop_front();
                if ({FrameOut, LineOut, PxOut, ColorPhase, FrameDone, FrameBufferEnable} !== e) begin
                    errors++;
                    $display("FAIL strobe got data=%h line=%0d px=%0d col=%b done=%b bank=%b required data=%h line=%0d px=%0d col=%b done=%b bank=%b",
                             FrameOut, LineOut, PxOut, ColorPhase, FrameDone, FrameBufferEnable,
                             e.data, e.line, e.px, e.color, e.done, e.bank);
                end
                last1 = e;
            end
        end else if ({FrameOut, LineOut, PxOut, ColorPhase, FrameDone} !==
                     {last1.data, last1.line, last1.px, last1.color, 1'b0}) begin
            errors++;
            $display("FAIL hold got data=%h line=%0d px=%0d col=%b done=%b required data=%h line=%0d px=%0d col=%b done=0",
                     FrameOut, LineOut, PxOut, ColorPhase, FrameDone,
                     last1.data, last1.line, last1.px, last1.color);
        end
    end

    always @(negedge Clock) begin
        exp_t e;
        if (WriteStrobe2) begin
            strobes2++;
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL stray_strobe2 got data=%h px=%0d required no strobe", FrameOut2, PxOut2);
            end else begin
                e = q2.pop_front();
                if ({FrameOut2, LineOut2, PxOut2, ColorPhase2, FrameDone2, FrameBufferEnable2} !== e) begin
                    errors++;
                    $display("FAIL strobe2 got data=%h line=%0d px=%0d col=%b done=%b bank=%b required data=%h line=%0d px=%0d col=%b done=%b bank=%b",
                             FrameOut2, LineOut2, PxOut2, ColorPhase2, FrameDone2, FrameBufferEnable2,
                             e.data, e.line, e.px, e.color, e.done, e.bank);
                end
            end
        end else if (FrameDone2 !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL done2_without_strobe got done=%b required 0", FrameDone2);
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic exp_t make_exp(input int n, input int pixels, input int lines,
                                      input logic [7:0] data, input logic bank);
        exp_t e;
        int   k;
        k       = n / 3;
        e.data  = data;
        e.px    = 4'(k % pixels);
        e.line  = 4'(k / pixels);
        e.color = 2'((n % 3) + 1);
        e.done  = (n == 3 * pixels * lines - 1);
        e.bank  = bank;
        return e;
    endfunction

    // One frame on the 10x10 instance. toggle: DataValid alternates 1/0.
    // start_at: transfer index where a stray Start is pulsed (-1 none).
    // abort_at: number of transfers after which Reset is applied (-1 none).
    task automatic run_frame(input bit toggle, input int start_at, input int abort_at);
        int n = 0;
        int cyc = 0;
        int s0;
        s0 = strobes1;
        // Start cycle: the byte offered while IDLE must be ignored.
        Start = 1'b1; DataValid = 1'b1; DataIn = 8'hEE;
        tick();
        Start = 1'b0;
        while (n < 300 && !(abort_at >= 0 && n == abort_at)) begin
            if (toggle && (cyc % 2 == 1)) begin
                DataValid = 1'b0; DataIn = 8'h5A; Start = 1'b0;
            end else begin
                DataValid = 1'b1;
                DataIn    = 8'(n % 44);
                Start     = (n == start_at);
                q1.push_back(make_exp(n, 10, 10, 8'(n % 44), exp_bank));
                n++;
            end
            cyc++;
            tick();
        end
        if (abort_at >= 0) begin
            // Reset overrides a transfer and a Start in the same cycle.
            Reset = 1'b1; DataValid = 1'b1; Start = 1'b1; DataIn = 8'hC3;
            tick();
            @(negedge Clock);
            chk("abort_busy",   {7'd0, Busy}, 8'd0);
            chk("abort_ready",  {7'd0, DataReady}, 8'd0);
            chk("abort_strobe", {7'd0, WriteStrobe}, 8'd0);
            chk("abort_done",   {7'd0, FrameDone}, 8'd0);
            chk("abort_bank",   {7'd0, FrameBufferEnable}, 8'd0);
            chk("abort_out",    FrameOut, 8'd0);
            chk("abort_addr",   {LineOut, PxOut}, 8'd0);
            chk("abort_color",  {6'd0, ColorPhase}, 8'd0);
            @(posedge Clock); #1;
            Reset = 1'b0; DataValid = 1'b0; Start = 1'b0;
            exp_bank = 1'b0;
            tick();
            @(negedge Clock);
            chk("abort_idle_busy", {7'd0, Busy}, 8'd0);
        end else begin
            // DONE cycle: byte and Start offered here must both be dropped.
            DataValid = 1'b1; DataIn = 8'hA5; Start = 1'b1;
            @(negedge Clock);
            chk("done_busy",  {7'd0, Busy}, 8'd1);
            chk("done_ready", {7'd0, DataReady}, 8'd0);
            @(posedge Clock); #1;
            Start = 1'b0; DataValid = 1'b0;
            @(negedge Clock);
            chk("after_done_busy", {7'd0, Busy}, 8'd0);
            @(posedge Clock); #1;
            @(negedge Clock);
            chk("start_not_queued_busy", {7'd0, Busy}, 8'd0);
`ifdef FRAME_SEQ_BANK_SWAP_EN
            exp_bank = ~exp_bank;
`endif
        end
        chk("strobe_count", 8'(strobes1 - s0), 8'(n));
        chk("queue_empty",  8'(q1.size()), 8'd0);
        @(posedge Clock); #1;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; DataValid = 1'b0; DataIn = 8'h00;
        Start2 = 1'b0; DataValid2 = 1'b0; DataIn2 = 8'h00;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_busy",   {7'd0, Busy}, 8'd0);
        chk("rst_ready",  {7'd0, DataReady}, 8'd0);
        chk("rst_strobe", {7'd0, WriteStrobe}, 8'd0);
        chk("rst_done",   {7'd0, FrameDone}, 8'd0);
        chk("rst_bank",   {7'd0, FrameBufferEnable}, 8'd0);
        chk("rst_out",    FrameOut, 8'd0);
        chk("rst_addr",   {LineOut, PxOut}, 8'd0);
        chk("rst_color",  {6'd0, ColorPhase}, 8'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        tick();

        run_frame(1'b0, -1, -1);   // back-to-back frame, bank 0
        run_frame(1'b1, 50, -1);   // toggled valid + stray Start, bank alternates
        run_frame(1'b0, -1, 100);  // abort after 100 transfers
        run_frame(1'b0, -1, -1);   // fresh frame after reset, bank 0 again

        // Small instance: 2 pixels x 1 line.
        Start2 = 1'b1;
        tick();
        Start2 = 1'b0;
        for (int n = 0; n < 6; n++) begin
            DataValid2 = 1'b1;
            DataIn2    = 8'(8'h30 + n);
            q2.push_back(make_exp(n, 2, 1, 8'(8'h30 + n), 1'b0));
            tick();
        end
        DataValid2 = 1'b0;
        @(negedge Clock);
        chk("small_done_busy", {7'd0, Busy2}, 8'd1);
        @(posedge Clock); #1;
        @(negedge Clock);
        chk("small_idle_busy",  {7'd0, Busy2}, 8'd0);
        chk("small_idle_ready", {7'd0, DataReady2}, 8'd0);
        chk("small_strobes",    8'(strobes2), 8'd6);
        chk("small_queue",      8'(q2.size()), 8'd0);

        repeat (2) @(posedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
